// File: rtl/peak_pair_hasher_if.sv
// Bundle between the peak finder, the pair hasher and the fingerprint store.
// The hasher takes the slave view: frames come in and hashes go out.
interface peak_pair_hasher_if #(
  parameter int N_MAX  = 16,
  parameter int BIN_W  = 9,
  parameter int MAG_W  = 16,
  parameter int DT_W   = 4,
  parameter int TIME_W = 16
);
  logic [N_MAX-1:0][BIN_W+MAG_W-1:0] maxima;
  logic                              maxima_valid;
  logic [2*BIN_W+DT_W-1:0]           hash_data;
  logic [TIME_W-1:0]                 hash_time;
  logic                              hash_valid;
  logic                              hash_ready;
  logic                              frame_done;
  logic                              overflow;

  modport master (
    output maxima, maxima_valid, hash_ready,
    input  hash_data, hash_time, hash_valid, frame_done, overflow
  );

  modport slave (
    input  maxima, maxima_valid, hash_ready,
    output hash_data, hash_time, hash_valid, frame_done, overflow
  );
endinterface

// File: rtl/peak_pair_hasher.sv
// Pairs each strong peak of the newest frame with the strong peaks of the previous
// HIST frames and streams the resulting {anchor, target, dt} hashes out one per beat.
module peak_pair_hasher #(
  parameter int               BIN_W      = 9,
  parameter int               MAG_W      = 16,
  parameter int               PEAKS      = 4,
  parameter int               HIST       = 3,
  parameter int               DT_W       = 4,
  parameter int               TIME_W     = 16,
  parameter logic [MAG_W-1:0] MAG_THRESH = 16'd64
) (
  input logic               clk,
  input logic               reset,
  peak_pair_hasher_if.slave bus
);
  localparam int HIDX_W = (HIST > 1) ? $clog2(HIST) : 1;
  localparam int PIDX_W = (PEAKS > 1) ? $clog2(PEAKS) : 1;
  localparam int HASH_W = 2 * BIN_W + DT_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PAIR   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]        r_state;
  logic [BIN_W-1:0]  r_curBin [PEAKS];
  logic [PEAKS-1:0]  r_curV;
  // Slot 0 holds the frame at dt=1, slot HIST-1 the oldest anchor frame.
  logic [BIN_W-1:0]  r_histBin [HIST][PEAKS];
  logic [PEAKS-1:0]  r_histV [HIST];
  logic [HIDX_W-1:0] r_hIdx;
  logic [PIDX_W-1:0] r_a;
  logic [PIDX_W-1:0] r_t;
  logic              r_scanDone;
  logic [TIME_W-1:0] r_frameCount;
  logic              r_hashValid;
  logic [HASH_W-1:0] r_hashData;
  logic [TIME_W-1:0] r_hashTime;
  logic              r_frameDone;
  logic              r_overflow;

  logic [DT_W-1:0]   w_dt;
  logic              w_candValid;
  logic              w_lastT;
  logic              w_lastA;
  logic              w_lastH;
  logic              w_lastCand;
  logic              w_slotFree;

  assign w_dt        = DT_W'(r_hIdx) + DT_W'(1);
  assign w_candValid = r_histV[r_hIdx][r_a] && r_curV[r_t];
  assign w_lastT     = (r_t == PIDX_W'(PEAKS - 1));
  assign w_lastA     = (r_a == PIDX_W'(PEAKS - 1));
  assign w_lastH     = (r_hIdx == HIDX_W'(HIST - 1));
  assign w_lastCand  = w_lastT && w_lastA && w_lastH;
  // The output register can take a new candidate once the held hash is gone or leaving now.
  assign w_slotFree  = !r_hashValid || bus.hash_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_curV       <= '0;
      for (int k = 0; k < HIST; k++) r_histV[k] <= '0;
      r_hIdx       <= '0;
      r_a          <= '0;
      r_t          <= '0;
      r_scanDone   <= 1'b0;
      r_frameCount <= '0;
      r_hashValid  <= 1'b0;
      r_hashData   <= '0;
      r_hashTime   <= '0;
      r_frameDone  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (bus.maxima_valid && (r_state != S_IDLE)) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.maxima_valid) begin
            for (int i = 0; i < PEAKS; i++) begin
              r_curBin[i] <= bus.maxima[i][BIN_W+MAG_W-1:MAG_W];
              r_curV[i]   <= (bus.maxima[i][MAG_W-1:0] >= MAG_THRESH);
            end
            r_hIdx     <= '0;
            r_a        <= '0;
            r_t        <= '0;
            r_scanDone <= 1'b0;
            r_state    <= S_PAIR;
          end
        end

        S_PAIR: begin
          if (w_slotFree) begin
            if (r_scanDone) begin
              r_hashValid <= 1'b0;
              r_frameDone <= 1'b1;
              r_state     <= S_COMMIT;
            end else begin
              r_hashValid <= w_candValid;
              if (w_candValid) begin
                r_hashData <= {r_histBin[r_hIdx][r_a], r_curBin[r_t], w_dt};
                r_hashTime <= r_frameCount - TIME_W'(w_dt);
              end
              // An invalid final candidate has nothing to drain, so commit right away.
              if (w_lastCand) begin
                r_scanDone <= 1'b1;
                if (!w_candValid) begin
                  r_frameDone <= 1'b1;
                  r_state     <= S_COMMIT;
                end
              end else if (w_lastT) begin
                r_t <= '0;
                if (w_lastA) begin
                  r_a    <= '0;
                  r_hIdx <= r_hIdx + HIDX_W'(1);
                end else begin
                  r_a <= r_a + PIDX_W'(1);
                end
              end else begin
                r_t <= r_t + PIDX_W'(1);
              end
            end
          end
        end

        S_COMMIT: begin
          for (int k = HIST - 1; k > 0; k--) begin
            r_histBin[k] <= r_histBin[k-1];
            r_histV[k]   <= r_histV[k-1];
          end
          r_histBin[0] <= r_curBin;
          r_histV[0]   <= r_curV;
          r_frameCount <= r_frameCount + TIME_W'(1);
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hash_valid = r_hashValid;
  assign bus.hash_data  = r_hashData;
  assign bus.hash_time  = r_hashTime;
  assign bus.frame_done = r_frameDone;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_peak_pair_hasher.sv
// Scoreboard bench: stimulus pushes expected hashes from a frame-history model,
// an independent monitor pops and compares every accepted beat.
module tb_peak_pair_hasher;
  localparam int N_MAX   = 16;
  localparam int BIN_W   = 9;
  localparam int MAG_W   = 16;
  localparam int PEAKS   = 4;
  localparam int HIST    = 3;
  localparam int DT_W    = 4;
  localparam int TIME_W  = 16;
  localparam int THRESH  = 64;
  localparam int ENTRY_W = BIN_W + MAG_W;
  localparam int HASH_W  = 2 * BIN_W + DT_W;

  typedef logic [N_MAX-1:0][ENTRY_W-1:0] frame_t;
  typedef logic [HASH_W+TIME_W-1:0]      beat_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     checks = 0;
  int     failures = 0;
  beat_t  expQ[$];
  frame_t histQ[$];
  int     frameNum = 0;
  int     framesAccepted = 0;
  int     frameDoneSeen = 0;
  int     beatsSeen = 0;
  int     readyMode = 1;
  logic   prevHold = 1'b0;
  beat_t  prevBeat = '0;

  always #5 clk = ~clk;

  peak_pair_hasher_if #(.N_MAX(N_MAX), .BIN_W(BIN_W), .MAG_W(MAG_W), .DT_W(DT_W), .TIME_W(TIME_W)) bus ();

  peak_pair_hasher #(
    .BIN_W(BIN_W), .MAG_W(MAG_W), .PEAKS(PEAKS), .HIST(HIST),
    .DT_W(DT_W), .TIME_W(TIME_W), .MAG_THRESH(16'd64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic frame_t setEntry(input frame_t f, input int idx, input int bin, input int mag);
    frame_t r;
    r = f;
    r[idx] = {BIN_W'(bin), MAG_W'(mag)};
    return r;
  endfunction

  function automatic logic [MAG_W-1:0] magOf(input frame_t f, input int i);
    return f[i][MAG_W-1:0];
  endfunction

  function automatic logic [BIN_W-1:0] binOf(input frame_t f, input int i);
    return f[i][ENTRY_W-1:MAG_W];
  endfunction

  // Sorted-descending random list, as the peak finder would deliver.
  function automatic frame_t randFrame();
    frame_t f;
    int m;
    m = int'($urandom_range(30, 400));
    for (int i = 0; i < N_MAX; i++) begin
      f[i] = {BIN_W'($urandom_range(0, 511)), MAG_W'(m)};
      m = m - int'($urandom_range(0, 40));
      if (m < 0) m = 0;
    end
    return f;
  endfunction

  // Reference: every strong peak of each remembered frame (newest first) against every strong peak of the new one.
  task automatic modelFrame(input frame_t f);
    for (int dt = 1; dt <= histQ.size(); dt++)
      for (int a = 0; a < PEAKS; a++)
        for (int t = 0; t < PEAKS; t++)
          if (magOf(histQ[dt-1], a) >= THRESH && magOf(f, t) >= THRESH)
            expQ.push_back({binOf(histQ[dt-1], a), binOf(f, t), DT_W'(dt), TIME_W'(frameNum - dt)});
    histQ.push_front(f);
    if (histQ.size() > HIST) void'(histQ.pop_back());
    frameNum = (frameNum + 1) % (1 << TIME_W);
  endtask

  task automatic applyStimulus(input frame_t f, input bit accept);
    @(posedge clk); #1;
    bus.maxima       = f;
    bus.maxima_valid = 1'b1;
    if (accept) begin
      modelFrame(f);
      framesAccepted++;
    end
    @(posedge clk); #1;
    bus.maxima_valid = 1'b0;
  endtask

  task automatic waitFrames(input int budget, input string name);
    int n;
    n = 0;
    while (frameDoneSeen < framesAccepted && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, 64'(frameDoneSeen), 64'(framesAccepted));
  endtask

  task automatic waitValid(input int budget, input string name);
    int n;
    n = 0;
    while (!bus.hash_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(bus.hash_valid), 64'd1);
  endtask

  task automatic doReset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    expQ.delete();
    histQ.delete();
    frameNum = 0;
    framesAccepted = frameDoneSeen;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    @(negedge clk);
    checkOutput({tag, "_hash_valid"}, 64'(bus.hash_valid), 64'd0);
    checkOutput({tag, "_hash_data"},  64'(bus.hash_data),  64'd0);
    checkOutput({tag, "_hash_time"},  64'(bus.hash_time),  64'd0);
    checkOutput({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    checkOutput({tag, "_overflow"},   64'(bus.overflow),   64'd0);
  endtask

  initial begin
    bus.hash_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       bus.hash_ready = 1'b0;
        1:       bus.hash_ready = 1'b1;
        default: bus.hash_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: ready seen at the falling edge is what the next rising edge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold) begin
          checkOutput("stall_valid_held", 64'(bus.hash_valid), 64'd1);
          checkOutput("stall_beat_stable", 64'({bus.hash_data, bus.hash_time}), 64'(prevBeat));
        end
        if (bus.hash_valid && bus.hash_ready) begin
          beatsSeen++;
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_hash: got 0x%0h, expected no beat", {bus.hash_data, bus.hash_time});
          end else begin
            checkOutput("hash_beat", 64'({bus.hash_data, bus.hash_time}), 64'(expQ.pop_front()));
          end
        end
        prevHold = bus.hash_valid && !bus.hash_ready;
        prevBeat = {bus.hash_data, bus.hash_time};
        if (bus.frame_done) begin
          frameDoneSeen++;
          checkOutput("hashes_drained_at_done", 64'(expQ.size()), 64'd0);
        end
      end
    end
  end

  initial begin
    frame_t f;
    int base;
    bus.maxima       = '0;
    bus.maxima_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkResetValues("reset");

    // First frame after reset has no anchors.
    f = setEntry('0, 0, 10, 500);
    f = setEntry(f, 1, 20, 400);
    applyStimulus(f, 1'b1);
    waitFrames(200, "frame0_done");
    checkOutput("frame0_no_hashes", 64'(beatsSeen), 64'd0);
    f = setEntry('0, 0, 30, 300);
    applyStimulus(f, 1'b1);
    waitFrames(200, "frame1_done");
    checkOutput("frame1_two_hashes", 64'(beatsSeen), 64'd2);

    // Single-peak frames: three anchors at dt 1..3, then the oldest ages out.
    doReset(2);
    base = beatsSeen;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(setEntry('0, 0, 5 + i, 100), 1'b1);
      waitFrames(200, "aging_done");
    end
    checkOutput("aging_frame3_beats", 64'(beatsSeen - base), 64'd6);
    applyStimulus(setEntry('0, 0, 9, 100), 1'b1);
    waitFrames(200, "aging_frame4_done");
    checkOutput("aging_frame4_beats", 64'(beatsSeen - base), 64'd9);

    // Downstream stall for 10 cycles in the middle of a frame.
    f = '0;
    for (int i = 0; i < PEAKS; i++) f = setEntry(f, i, 100 + i, 1000 - i);
    applyStimulus(f, 1'b1);
    waitValid(100, "stall_first_valid");
    readyMode = 0;
    repeat (10) @(posedge clk);
    readyMode = 1;
    waitFrames(400, "stall_frame_done");

    // A frame arriving mid-pairing is dropped and flagged.
    checkOutput("overflow_clear", 64'(bus.overflow), 64'd0);
    applyStimulus(randFrame(), 1'b1);
    repeat (3) @(posedge clk);
    applyStimulus(randFrame(), 1'b0);
    waitFrames(400, "overflow_frame_done");
    checkOutput("overflow_set", 64'(bus.overflow), 64'd1);
    applyStimulus(randFrame(), 1'b1);
    waitFrames(400, "after_overflow_done");
    checkOutput("overflow_sticky", 64'(bus.overflow), 64'd1);

    // Threshold boundary: 63 excluded, 64 included.
    doReset(2);
    checkOutput("overflow_cleared_by_reset", 64'(bus.overflow), 64'd0);
    base = beatsSeen;
    f = setEntry('0, 0, 12, 64);
    f = setEntry(f, 1, 11, 63);
    applyStimulus(f, 1'b1);
    waitFrames(200, "thresh_frame0_done");
    f = setEntry('0, 0, 13, 64);
    f = setEntry(f, 1, 14, 63);
    applyStimulus(f, 1'b1);
    waitFrames(200, "thresh_frame1_done");
    checkOutput("thresh_beats", 64'(beatsSeen - base), 64'd1);

    // Random frames with random back-pressure.
    readyMode = 2;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randFrame(), 1'b1);
      waitFrames(1000, "random_frame_done");
    end
    readyMode = 1;

    // Reset while a hash is held mid-pairing.
    f = '0;
    for (int i = 0; i < PEAKS; i++) f = setEntry(f, i, 200 + i, 500 - i);
    applyStimulus(f, 1'b1);
    waitValid(100, "midreset_first_valid");
    readyMode = 0;
    repeat (2) @(posedge clk);
    doReset(1);
    checkResetValues("midreset");
    readyMode = 1;
    base = beatsSeen;
    applyStimulus(f, 1'b1);
    waitFrames(200, "post_reset_frame_done");
    checkOutput("post_reset_no_history", 64'(beatsSeen - base), 64'd0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
